// File: rtl/ldst_mem_unit_pkg.sv
// rtl/ldst_mem_unit_pkg.sv - shared types and lane constants for the load/store memory unit
package ldst_mem_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } ldst_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  localparam logic [3:0] MBE_B = 4'b0001;
  localparam logic [3:0] MBE_H = 4'b0011;
  localparam logic [3:0] MBE_W = 4'b1111;

endpackage

// File: rtl/ldst_mem_unit_if.sv
// rtl/ldst_mem_unit_if.sv - LSQ request, data-memory port and CDB result bundle
interface ldst_mem_unit_if #(
  parameter int TAG_W = 4
) ();

  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             dmem_read;
  logic             dmem_write;
  logic [31:0]      dmem_address;
  logic [31:0]      dmem_wdata;
  logic [3:0]       dmem_mbe;
  logic [31:0]      dmem_rdata;
  logic             dmem_resp;
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;
  logic             res_is_store;
  logic             res_fault;

  modport master (
    output flush, req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
    output dmem_rdata, dmem_resp, res_ready,
    input  req_ready, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  res_valid, res_tag, res_data, res_is_store, res_fault
  );

  modport slave (
    input  flush, req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
    input  dmem_rdata, dmem_resp, res_ready,
    output req_ready, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output res_valid, res_tag, res_data, res_is_store, res_fault
  );

endinterface

// File: rtl/ldst_mem_unit_align.sv
// rtl/ldst_mem_unit_align.sv - byte-lane encode for stores, extract/extend for loads, fault detect
module ldst_mem_unit_align
  import ldst_mem_unit_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mbe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_fault
);

  logic [31:0] w_shift;
  logic        w_legal;

  always_comb begin
    w_shift = i_rdata >> {i_off, 3'b000};
    w_legal = i_is_store ? (i_funct3 <= SW)
                         : (i_funct3 != 3'b011 && i_funct3 < 3'b110);
    o_mbe   = 4'b0000;
    o_wdata = 32'h0;
    o_ldata = 32'h0;
    o_fault = !w_legal;

    // funct3[1:0] carries the access size for both loads and stores
    case (i_funct3[1:0])
      2'b00: begin
        o_mbe   = MBE_B << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_mbe   = MBE_H << i_off;
        o_wdata = {2{i_wdata[15:0]}};
        o_fault = o_fault | i_off[0];
      end
      2'b10: begin
        o_mbe   = MBE_W;
        o_wdata = i_wdata;
        o_fault = o_fault | (|i_off);
      end
      default: o_fault = 1'b1;
    endcase

    case (i_funct3)
      LB:      o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      LH:      o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      LW:      o_ldata = w_shift;
      LBU:     o_ldata = {24'h0, w_shift[7:0]};
      LHU:     o_ldata = {16'h0, w_shift[15:0]};
      default: o_ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/ldst_mem_unit.sv
// rtl/ldst_mem_unit.sv - single-op load/store executor: FSM plus op and result registers
module ldst_mem_unit
  import ldst_mem_unit_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  ldst_mem_unit_if.slave bus
);

  ldst_state_t      r_state;
  ldst_state_t      w_next_state;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr;
  logic [3:0]       r_mbe;
  logic [31:0]      r_wdata;
  logic [TAG_W-1:0] r_tag;
  logic             r_fault;
  logic [31:0]      r_data;

  logic             w_accept;
  logic             w_al_is_store;
  logic [2:0]       w_al_funct3;
  logic [1:0]       w_al_off;
  logic [3:0]       w_mbe;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ldata;
  logic             w_fault;

  assign w_accept = (r_state == IDLE) && bus.req_valid && !bus.flush;

  // One aligner serves both phases: request fields while idle, latched op afterwards
  assign w_al_is_store = (r_state == IDLE) ? bus.req_is_store   : r_is_store;
  assign w_al_funct3   = (r_state == IDLE) ? bus.req_funct3     : r_funct3;
  assign w_al_off      = (r_state == IDLE) ? bus.req_addr[1:0]  : r_addr[1:0];

  ldst_mem_unit_align u_align (
    .i_is_store (w_al_is_store),
    .i_funct3   (w_al_funct3),
    .i_off      (w_al_off),
    .i_wdata    (bus.req_wdata),
    .i_rdata    (bus.dmem_rdata),
    .o_mbe      (w_mbe),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_fault    (w_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next_state = w_fault ? RESP : ACCESS;
      ACCESS: begin
        if (bus.flush)          w_next_state = bus.dmem_resp ? IDLE : DRAIN;
        else if (bus.dmem_resp) w_next_state = RESP;
      end
      DRAIN:  if (bus.dmem_resp) w_next_state = IDLE;
      RESP:   if (bus.flush || bus.res_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_mbe      <= 4'b0000;
      r_wdata    <= 32'h0;
      r_tag      <= '0;
      r_fault    <= 1'b0;
      r_data     <= 32'h0;
    end else if (w_accept) begin
      r_is_store <= bus.req_is_store;
      r_funct3   <= bus.req_funct3;
      r_addr     <= bus.req_addr;
      r_mbe      <= w_fault ? 4'b0000 : w_mbe;
      r_wdata    <= (bus.req_is_store && !w_fault) ? w_wdata : 32'h0;
      r_tag      <= bus.req_tag;
      r_fault    <= w_fault;
      r_data     <= 32'h0;
    end else if (r_state == ACCESS && bus.dmem_resp && !bus.flush) begin
      r_data     <= r_is_store ? 32'h0 : w_ldata;
    end
  end

  always_comb begin
    bus.req_ready    = (r_state == IDLE);
    bus.dmem_read    = (r_state == ACCESS || r_state == DRAIN) && !r_is_store;
    bus.dmem_write   = (r_state == ACCESS || r_state == DRAIN) && r_is_store;
    bus.dmem_address = {r_addr[31:2], 2'b00};
    bus.dmem_wdata   = r_wdata;
    bus.dmem_mbe     = r_mbe;
    bus.res_valid    = (r_state == RESP);
    bus.res_tag      = r_tag;
    bus.res_data     = r_data;
    bus.res_is_store = r_is_store;
    bus.res_fault    = r_fault;
  end

endmodule

// File: tb/tb_ldst_mem_unit.sv
// tb/tb_ldst_mem_unit.sv - randomized self-checking bench against a behavioural load/store model
module tb_ldst_mem_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldst_mem_unit_if #(.TAG_W(4)) bus ();
  ldst_mem_unit #(.TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    logic [1:0] sz_code;
    sz_code = f3[1:0];
    return 1 << sz_code;
  endfunction

  function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [1:0] off);
    if (st && f3 > 3'd2) return 1'b1;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    return (int'(off) % ref_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [1:0] off);
    int lanes;
    lanes = ((1 << ref_size(f3)) - 1) << off;
    return lanes[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (ref_size(f3))
      1:       return {24'h0, wd[7:0]} * 32'h01010101;
      2:       return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] full;
    int bits;
    bits = 8 * ref_size(f3);
    v = rd >> (8 * off);
    if (bits == 32) return v;
    full = 32'd1 << bits;
    v = v % full;
    if (!f3[2] && v >= (full >> 1)) v = v - full;
    return v;
  endfunction

  // Called at a falling edge with the unit idle; fmode 0 normal, 1 flush mid-ACCESS,
  // 2 flush coincident with resp, 3 flush instead of grant in RESP.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] tag,
                        input int resp_k, input int grant_wait, input int fmode);
    bit          flt;
    logic [31:0] exp_data;
    flt = ref_fault(st, f3, addr[1:0]);
    check_eq("req_ready_idle", {31'h0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_tag      = tag;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (flt) begin
      exp_data = 32'h0;
      check_eq("fault_valid", {31'h0, bus.res_valid}, 32'd1);
      check_eq("fault_flag", {31'h0, bus.res_fault}, 32'd1);
      check_eq("fault_tag", {28'h0, bus.res_tag}, {28'h0, tag});
      check_eq("fault_strobes", {30'h0, bus.dmem_read, bus.dmem_write}, 32'd0);
      check_eq("fault_data", bus.res_data, 32'h0);
    end else begin
      for (int i = 1; i <= resp_k; i++) begin
        check_eq("strobes", {30'h0, bus.dmem_read, bus.dmem_write}, {30'h0, !st, st});
        check_eq("req_ready_busy", {31'h0, bus.req_ready}, 32'd0);
        if (i == 1) begin
          check_eq("address", bus.dmem_address, {addr[31:2], 2'b00});
          check_eq("mbe", {28'h0, bus.dmem_mbe}, {28'h0, ref_mbe(f3, addr[1:0])});
          check_eq("wdata", bus.dmem_wdata, st ? ref_wdata(f3, wd) : 32'h0);
        end
        if (i == resp_k) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = rd;
          if (fmode == 2) bus.flush = 1'b1;
        end
        if (fmode == 1 && i == 1) bus.flush = 1'b1;
        @(negedge clk);
        bus.dmem_resp  = 1'b0;
        bus.flush      = 1'b0;
        bus.dmem_rdata = $urandom;
      end
      check_eq("strobes_drop", {30'h0, bus.dmem_read, bus.dmem_write}, 32'd0);
      if (fmode == 1 || fmode == 2) begin
        check_eq("flushed_no_valid", {31'h0, bus.res_valid}, 32'd0);
        check_eq("flushed_ready", {31'h0, bus.req_ready}, 32'd1);
        return;
      end
      exp_data = st ? 32'h0 : ref_load(f3, addr[1:0], rd);
      check_eq("res_valid", {31'h0, bus.res_valid}, 32'd1);
      check_eq("res_fault", {31'h0, bus.res_fault}, 32'd0);
      check_eq("res_tag", {28'h0, bus.res_tag}, {28'h0, tag});
      check_eq("res_data", bus.res_data, exp_data);
    end
    check_eq("res_is_store", {31'h0, bus.res_is_store}, {31'h0, st});
    for (int i = 0; i < grant_wait; i++) begin
      bus.req_valid  = 1'b1;
      bus.req_addr   = $urandom;
      bus.req_funct3 = 3'($urandom_range(0, 7));
      @(negedge clk);
      check_eq("hold_valid", {31'h0, bus.res_valid}, 32'd1);
      check_eq("hold_data", bus.res_data, exp_data);
      check_eq("hold_ready", {31'h0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    if (fmode == 3) bus.flush = 1'b1;
    else            bus.res_ready = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.res_ready = 1'b0;
    check_eq("after_grant_valid", {31'h0, bus.res_valid}, 32'd0);
    check_eq("after_grant_ready", {31'h0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    int          fm;
    int          rk;
    bus.flush = 1'b0;        bus.req_valid = 1'b0;   bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'b0;   bus.req_addr = 32'h0;   bus.req_wdata = 32'h0;
    bus.req_tag = 4'h0;      bus.dmem_rdata = 32'h0; bus.dmem_resp = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
    check_eq("rst_res_valid", {31'h0, bus.res_valid}, 32'd0);
    check_eq("rst_strobes", {30'h0, bus.dmem_read, bus.dmem_write}, 32'd0);
    check_eq("rst_mbe_addr", {28'h0, bus.dmem_mbe} | bus.dmem_address, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'h3, 3, 0, 0);
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 4'h5, 1, 0, 0);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 4'h6, 2, 0, 0);
    run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 4'h7, 2, 1, 0);
    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 4'h9, 1, 0, 0);
    run_op(1'b0, 3'b010, 32'h200, 32'h0, 32'h11223344, 4'hA, 3, 0, 1);
    run_op(1'b0, 3'b001, 32'h202, 32'h0, 32'h8001FFFF, 4'hB, 1, 5, 0);
    run_op(1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 4'hC, 2, 0, 2);
    run_op(1'b0, 3'b101, 32'h302, 32'h0, 32'hF00D0000, 4'hD, 1, 2, 3);
    run_op(1'b1, 3'b011, 32'h304, 32'h0, 32'h0, 4'hE, 1, 1, 0);

    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr  = 32'h400;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    check_eq("flush_idle_ready", {31'h0, bus.req_ready}, 32'd1);
    check_eq("flush_idle_strobes", {30'h0, bus.dmem_read, bus.dmem_write}, 32'd0);

    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h500;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rst_mid_read", {31'h0, bus.dmem_read}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_strobes", {30'h0, bus.dmem_read, bus.dmem_write}, 32'd0);
    check_eq("rst_mid_ready", {31'h0, bus.req_ready}, 32'd1);
    @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      fm = ($urandom_range(0, 5) < 3) ? 0 : $urandom_range(1, 3);
      rk = $urandom_range(1, 4);
      if (ref_fault(st, f3, 2'(n)) && fm != 3) fm = 0;
      if (fm == 1 && rk < 2) rk = 2;
      run_op(st, f3, {$urandom_range(0, 32'h3FFF), 2'(n)}, $urandom, $urandom,
             4'($urandom_range(0, 15)), rk, $urandom_range(0, 3), fm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
